// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back buffer draining into the register file with forwarding lookup
module regfile_write_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wa,
  input  logic [DATA_W-1:0] in_wd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_ra,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CW-1:0]     count
);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  // accept/drain handshakes; writes to register 0 are consumed but never stored
  always_comb begin
    in_ready = count_q < CW'(DEPTH);
    rf_we    = count_q != '0;
    rf_wa    = rf_we ? addr_q[head_q] : '0;
    rf_wd    = rf_we ? data_q[head_q] : '0;
    push     = in_valid && in_ready && in_wa != '0;
    pop      = rf_we && rf_ready;
    head_d   = pop ? head_q + 1'b1 : head_q;
    tail_d   = push ? tail_q + 1'b1 : tail_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    count    = count_q;
  end
  // scan oldest to youngest so the last match, closest to tail, wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && fwd_ra != '0 && addr_q[head_q + PW'(i)] == fwd_ra) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
    end
  end
  // pointers, occupancy and storage; reset discards all pending writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= in_wa;
        data_q[tail_q] <= in_wd;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and randomized checks against a queue-based reference model
module tb_regfile_write_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_wa = '0;
  logic [63:0] in_wd = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic        rf_ready = 1'b0;
  logic [4:0]  fwd_ra = '0;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [2:0]  count;
  int checks = 0;
  int failures = 0;
  logic [68:0] q[$];
  logic [4:0]  drained[$];

  regfile_write_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wa(in_wa), .in_wd(in_wd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_ready(rf_ready), .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic void fwd_model(input logic [4:0] ra, output logic h, output logic [63:0] d);
    h = 1'b0;
    d = '0;
    if (ra != 0) foreach (q[i]) if (q[i][68:64] == ra) begin h = 1'b1; d = q[i][63:0]; end
  endfunction

  task automatic tick();
    bit acc, pp;
    acc = in_valid && q.size() < DEPTH;
    pp = q.size() != 0 && rf_ready;
    if (rf_we && rf_ready) drained.push_back(rf_wa);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc && in_wa != 0) q.push_back({in_wa, in_wd});
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_wa = 5'd3; in_wd = 64'h33; rf_ready = 1'b0;
    q.delete();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 64'd0) begin failures++; $display("FAIL reset_rf got we=%b wa=%0d wd=%h exp 0", rf_we, rf_wa, rf_wd); end
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin failures++; $display("FAIL reset_fwd got %b %h exp 0", fwd_hit, fwd_data); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_held_count got %0d exp 0", count); end
    reset = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3) begin failures++; $display("FAIL first_accept got we=%b wa=%0d exp we=1 wa=3", rf_we, rf_wa); end
    rf_ready = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL first_drain got we=%b exp 0", rf_we); end
  endtask

  task automatic test_fill();
    rf_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin in_wa = 5'(k); in_wd = 64'(k * 'h11); tick(); end
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_full got count=%0d rdy=%b exp 4 0", count, in_ready); end
    in_wa = 5'd9; in_wd = 64'h99; tick();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth got count=%0d exp 4", count); end
    in_valid = 1'b0; rf_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'(k) || rf_wd !== 64'(k * 'h11)) begin failures++; $display("FAIL fill_drain%0d got we=%b wa=%0d wd=%h exp wa=%0d", k, rf_we, rf_wa, rf_wd, k); end
      tick();
    end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL fill_empty got we=%b exp 0", rf_we); end
  endtask

  task automatic test_addr0();
    rf_ready = 1'b1; in_valid = 1'b1; in_wa = 5'd0; in_wd = 64'hDEAD;
    tick();
    checks++; if (count !== 3'd0 || rf_we !== 1'b0 || rf_wd === 64'hDEAD) begin failures++; $display("FAIL addr0_drop got count=%0d we=%b wd=%h exp 0 0", count, rf_we, rf_wd); end
    in_wa = 5'd5; in_wd = 64'h55;
    tick();
    in_valid = 1'b0; #1;
    checks++; if (count !== 3'd1 || rf_wa !== 5'd5 || rf_wd !== 64'h55) begin failures++; $display("FAIL addr0_next got count=%0d wa=%0d wd=%h exp 1 5 55", count, rf_wa, rf_wd); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL addr0_empty got we=%b exp 0", rf_we); end
  endtask

  task automatic test_forward();
    rf_ready = 1'b0; in_valid = 1'b1;
    in_wa = 5'd7; in_wd = 64'hA; tick();
    in_wd = 64'hB; tick();
    in_valid = 1'b0; fwd_ra = 5'd7; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hB) begin failures++; $display("FAIL fwd_youngest got %b %h exp 1 b", fwd_hit, fwd_data); end
    fwd_ra = 5'd0; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin failures++; $display("FAIL fwd_r0 got %b %h exp 0 0", fwd_hit, fwd_data); end
    fwd_ra = 5'd8; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin failures++; $display("FAIL fwd_miss got %b %h exp 0 0", fwd_hit, fwd_data); end
    fwd_ra = 5'd7; rf_ready = 1'b1; tick();
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hB) begin failures++; $display("FAIL fwd_head got %b %h exp 1 b", fwd_hit, fwd_data); end
    tick();
    checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_gone got %b exp 0", fwd_hit); end
  endtask

  task automatic test_back_to_back();
    rf_ready = 1'b1; in_valid = 1'b1; drained.delete();
    for (int k = 1; k <= 10; k++) begin
      in_wa = 5'(k); in_wd = 64'(k * 'h100); tick();
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count%0d got %0d exp 1", k, count); end
    end
    in_valid = 1'b0; tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_end got %0d exp 0", count); end
    checks++; if (drained.size() != 10) begin failures++; $display("FAIL stream_len got %0d exp 10", drained.size()); end
    foreach (drained[i]) begin
      checks++; if (drained[i] !== 5'(i + 1)) begin failures++; $display("FAIL stream_order%0d got %0d exp %0d", i, drained[i], i + 1); end
    end
  endtask

  task automatic test_mid_reset();
    rf_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin in_wa = 5'(k + 20); in_wd = 64'(k); tick(); end
    in_valid = 1'b0; #2;
    reset = 1'b1; #1;
    q.delete();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_async got we=%b count=%0d rdy=%b exp 0 0 1", rf_we, count, in_ready); end
    @(posedge clk); #1; reset = 1'b0; rf_ready = 1'b1; drained.delete();
    for (int k = 0; k < 4; k++) tick();
    checks++; if (drained.size() != 0 || count !== 3'd0) begin failures++; $display("FAIL midreset_stale got writes=%0d count=%0d exp 0 0", drained.size(), count); end
  endtask

  task automatic test_random();
    logic h;
    logic [63:0] d;
    logic [68:0] hd;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_wa = 5'($urandom_range(0, 7));
      in_wd = {$urandom, $urandom};
      rf_ready = 1'($urandom_range(0, 2) == 0);
      fwd_ra = 5'($urandom_range(0, 8));
      #1;
      fwd_model(fwd_ra, h, d);
      hd = q.size() != 0 ? q[0] : '0;
      checks++; if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_count n=%0d got %0d rdy=%b exp %0d", n, count, in_ready, q.size()); end
      checks++; if (rf_we !== (q.size() != 0) || rf_wa !== hd[68:64] || rf_wd !== hd[63:0]) begin failures++; $display("FAIL rnd_head n=%0d got we=%b wa=%0d wd=%h exp wa=%0d wd=%h", n, rf_we, rf_wa, rf_wd, hd[68:64], hd[63:0]); end
      checks++; if (fwd_hit !== h || fwd_data !== d) begin failures++; $display("FAIL rnd_fwd n=%0d got %b %h exp %b %h", n, fwd_hit, fwd_data, h, d); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_addr0();
    test_forward();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side companion to the register file. Buffers register write-back requests (address + 64-bit data) from the execute stage in a small in-order queue and drains them one per cycle into the register file write port. Also provides a forwarding lookup so readers can see data still pending in the queue. Writes to register 0 are discarded because register 0 is hardwired to zero.

## Interface
- DATA_W, 64, data width of one register
- ADDR_W, 5, register address width (32 registers)
- DEPTH, 4, queue entries; must be a power of 2, at least 2

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  write request present
- in_ready  out  1  queue can accept a request this cycle
- in_wa  in  ADDR_W  register address to write
- in_wd  in  DATA_W  data to write
- rf_we  out  1  write-enable to register file; high when queue is non-empty
- rf_wa  out  ADDR_W  head entry address
- rf_wd  out  DATA_W  head entry data
- rf_ready  in  1  register file accepts the write this cycle
- fwd_ra  in  ADDR_W  read address to look up
- fwd_hit  out  1  a pending entry matches fwd_ra
- fwd_data  out  DATA_W  data of the youngest matching entry
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- State: DEPTH-entry storage array (address, data), head and tail pointers (log2 DEPTH bits), and an occupancy counter.
- Accept: a request is accepted when in_valid && in_ready. in_ready = (count < DEPTH). It is a pure function of registered count and does not depend on in_valid or rf_ready.
- Address 0: an accepted request with in_wa == 0 is consumed. It does not change storage, tail or count.
- Push: storage[tail] <= {in_wa, in_wd}, then tail <= tail+1 (wraps modulo DEPTH).
- Drain: rf_we = (count != 0).
  - rf_wa and rf_wd come combinationally from storage[head] when rf_we is high. Both are 0 when the queue is empty.
  - A pop occurs when rf_we && rf_ready, then head <= head+1 (wraps).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - neither: unchanged
- Full: in_ready = 0 even if a pop occurs in the same cycle. There is no full-queue bypass.
- Empty: there is no bypass from input to rf_* outputs. A request is never written to the register file in the cycle it is accepted.
- Order: entries drain strictly in acceptance order. Duplicate addresses are kept as separate entries, with no merging.
- Forwarding (combinational):
  - Scan the valid entries from head to tail-1. fwd_hit = 1 if any entry address equals fwd_ra.
  - fwd_data = data of the youngest matching entry (closest to tail).
  - fwd_ra == 0 always gives fwd_hit = 0, fwd_data = 0. No match also gives fwd_data = 0.
  - The current-cycle input request is not included in the scan.
  - The head entry is included even in the cycle it is popped.

## Timing
- Reset (async assert, released synchronously by the environment):
  - head = tail = 0, count = 0, all storage = 0
  - Outputs: rf_we = 0, rf_wa = 0, rf_wd = 0, in_ready = 1, fwd_hit = 0, fwd_data = 0
- Reset mid-operation: all pending entries are lost and never written. Outputs return to reset values immediately, without waiting for a clock edge.
- Latency: a request accepted at edge N into an empty queue gives rf_we = 1 with its address and data during cycle N+1. With rf_ready held high, the pop happens at edge N+1.
- Throughput: one accept and one drain per cycle sustained (count stays constant).
- Forwarding visibility: an entry is visible to fwd_* from the cycle after its accept edge until its pop edge.
- Backpressure: while rf_ready = 0, rf_wa and rf_wd hold stable on the head entry.

## Test plan
- Reset with in_valid = 1 and in_wa = 3 held: after reset, in_ready = 1, count = 0, rf_we = 0.
  - The first edge after reset release accepts the request. Next cycle: rf_we = 1, rf_wa = 3.
- Fill with rf_ready = 0: push addresses 1, 2, 3, 4 with data 0x11, 0x22, 0x33, 0x44.
  - Result: count = 4, in_ready = 0.
  - A 5th request with in_valid = 1 is not accepted.
  - Raise rf_ready: rf_wa = 1, 2, 3, 4 on consecutive cycles, then rf_we = 0.
- Address 0 drop: push (0, 0xDEAD), then (5, 0x55).
  - count never exceeds 1; rf_wa = 5, rf_wd = 0x55; 0xDEAD never appears on rf_wd.
- Forwarding youngest-wins: with rf_ready = 0, push (7, 0xA) then (7, 0xB), and set fwd_ra = 7.
  - Result: fwd_hit = 1, fwd_data = 0xB.
  - With fwd_ra = 0: fwd_hit = 0. With fwd_ra = 8: fwd_hit = 0, fwd_data = 0.
- Simultaneous push/pop with wrap:
  - Stream 10 requests (addresses 1 to 10) with rf_ready = 1.
  - count stays at 1 after the first cycle, pointers wrap past DEPTH, and the drained order is 1 to 10.
- Mid-operation reset: with 3 entries queued, assert reset between edges.
  - rf_we drops to 0 immediately, and after release count = 0 with no stale writes.
